jk_bank_driver: RTL and testbench
=================================

# jk_bank_driver

Control block that drives the J/K inputs of a bank of `WIDTH` JK flip-flops so the bank reaches a requested target value. It accepts a target over a valid/ready handshake and applies the JK excitation derived from the bank's fed-back Q. It then checks the result, retries on mismatch, and reports completion or error. It sits upstream of the JK flop bank, on the opposite side of the J/K interface from the flops.

## Interface
- `WIDTH`, 4: number of JK flops driven; must be ≥ 1.
- `MAX_RETRY`, 3: extra DRIVE attempts after the first failed check; must be ≥ 0. The retry counter is `$clog2(MAX_RETRY+1)` bits, minimum 1.

Ports:
- `Clk`  in  1  sole clock; all state updates on rising edge.
- `Rst`  in  1  synchronous, active-high reset.
- `In_valid`  in  1  request strobe.
- `In_ready`  out  1  high only in IDLE; decoded from state.
- `Target`  in  WIDTH  requested bank value; sampled at accept.
- `Toggle_pref`  in  1  excitation mode; sampled at accept.
- `Q_fb`  in  WIDTH  Q outputs of the driven bank.
- `J`  out  WIDTH  registered J drive.
- `K`  out  WIDTH  registered K drive.
- `Busy`  out  1  registered; high from the cycle after accept until the cycle Done/Err is asserted, exclusive.
- `Done`  out  1  registered one-cycle success pulse.
- `Err`  out  1  registered one-cycle failure pulse.

## Operation
- FSM states: IDLE, DRIVE, CHECK.
- Accept happens on a rising edge with `In_valid && In_ready`. At that edge:
  - latch `Target` and `Toggle_pref`;
  - clear the retry counter;
  - load J/K with excitation(Q_fb, Target);
  - go to DRIVE.
- Per-bit excitation for q = Q_fb[i], t = target[i]:
  - q == t → J=0, K=0 (hold).
  - q≠t with `Toggle_pref`=0: t=1 → J=1, K=0; t=0 → J=0, K=1.
  - q≠t with `Toggle_pref`=1 → J=1, K=1 (toggle).
- DRIVE lasts exactly one cycle. At its end, J/K ← 0 and the FSM goes to CHECK unconditionally.
- CHECK lasts one cycle. At its end, compare Q_fb against the latched target:
  - Equal → Done ← 1, go to IDLE.
  - Unequal and retry count < MAX_RETRY → retry count +1, J/K ← excitation(Q_fb, latched target), go to DRIVE.
  - Unequal and retry count == MAX_RETRY → Err ← 1, go to IDLE.
- J/K are zero in every cycle except DRIVE cycles, so the bank holds outside DRIVE.
- `In_valid` is ignored whenever `In_ready`=0. No queuing.
- A target equal to Q_fb at accept still runs DRIVE (J=K=0) and CHECK, then Done.
- Done and Err are mutually exclusive. Each is exactly one cycle wide.

## Timing
- Reset values: state IDLE, J=0, K=0, Busy=0, Done=0, Err=0, retry count 0, latched target 0. `In_ready`=1 from the first cycle after reset.
- `Rst` takes priority over every transition, including accept. Reset during DRIVE or CHECK aborts the operation: J/K, Busy, Done and Err are 0 in the next cycle, and neither Done nor Err is ever produced for the aborted request.
- Cycle numbering: accept edge E0 begins cycle 1.
  - Cycle 1: DRIVE, J/K valid, Busy=1. The bank captures at E1.
  - Cycle 2: CHECK, J/K=0, Q_fb carries the new value.
  - At E2: decision.
  - Cycle 3: Done or Err high, IDLE, `In_ready`=1, Busy=0.
- Success with no retry: 3 cycles from accept edge to the Done cycle.
- Each retry adds 2 cycles. Worst case, Err appears in cycle 3 + 2·MAX_RETRY.
- Back-to-back operation: a new accept is allowed at the edge ending the Done/Err cycle.

## Test plan
All scenarios use WIDTH=4, MAX_RETRY=3 and a behavioural JK bank on J/K/Q_fb, except scenario 4.
1. Reset: hold Rst for 2 cycles with In_valid=1 → J=K=0000, Busy=Done=Err=0, In_ready=1, no accept.
2. Bank=0000, Target=1010, Toggle_pref=0 → cycle 1 J=1010, K=0000; cycle 3 Done=1; bank=1010; J/K=0 in all other cycles.
3. Bank=1010, Target=0110:
   - Toggle_pref=0 → J=0100, K=1000.
   - Toggle_pref=1 → J=K=1100.
   - Both modes: Done in cycle 3 and bank=0110.
4. Q_fb stuck at 0000, Target=0001 → 4 DRIVE cycles, each with J=0001 (cycles 1, 3, 5, 7); Err=1 in cycle 9; Done never asserted.
5. Rst asserted in cycle 2 (CHECK) of a request → cycle 3 IDLE, Done=Err=0, J=K=0. A new request afterwards completes normally.
6. Target equals bank (0101), with In_valid held high throughout → J=K=0 in cycle 1; Done in cycle 3; second accept at the end of cycle 3, none earlier.

Source files
------------

// File: rtl/jk_bank_driver.sv
// Drives J/K of a JK flop bank toward a requested target: DRIVE one cycle, CHECK one cycle, retry on mismatch.
// Done/Err three cycles after accept (+2 per retry); In_ready only in IDLE, requests are never queued.
module jk_bank_driver #(
    parameter int WIDTH     = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [WIDTH-1:0] Target,
    input  logic             Toggle_pref,
    input  logic [WIDTH-1:0] Q_fb,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             Busy,
    output logic             Done,
    output logic             Err
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_CHECK
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             pref_q, pref_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic [WIDTH-1:0] j_q, j_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // In IDLE the excitation is built from the live request, otherwise from the latched one.
    logic [WIDTH-1:0] exc_t;
    logic             exc_pref;
    logic [WIDTH-1:0] exc_diff;
    logic [WIDTH-1:0] exc_j;
    logic [WIDTH-1:0] exc_k;

    always_comb begin
        exc_t    = (state_q == S_IDLE) ? Target : target_q;
        exc_pref = (state_q == S_IDLE) ? Toggle_pref : pref_q;
        exc_diff = Q_fb ^ exc_t;
        exc_j    = exc_diff & (exc_pref ? {WIDTH{1'b1}} : exc_t);
        exc_k    = exc_diff & (exc_pref ? {WIDTH{1'b1}} : ~exc_t);
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        pref_d   = pref_q;
        retry_d  = retry_q;
        j_d      = '0;
        k_d      = '0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (In_valid) begin
                    target_d = Target;
                    pref_d   = Toggle_pref;
                    retry_d  = '0;
                    j_d      = exc_j;
                    k_d      = exc_k;
                    busy_d   = 1'b1;
                    state_d  = S_DRIVE;
                end
            end
            S_DRIVE: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (Q_fb == target_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (retry_q < RETRY_LIMIT) begin
                    retry_d = retry_q + 1'b1;
                    j_d     = exc_j;
                    k_d     = exc_k;
                    state_d = S_DRIVE;
                end else begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= S_IDLE;
            target_q <= '0;
            pref_q   <= 1'b0;
            retry_q  <= '0;
            j_q      <= '0;
            k_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            pref_q   <= pref_d;
            retry_q  <= retry_d;
            j_q      <= j_d;
            k_q      <= k_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign In_ready = (state_q == S_IDLE);
    assign J        = j_q;
    assign K        = k_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Err      = err_q;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Scoreboard bench for jk_bank_driver with a behavioural JK bank (optionally stuck at zero).
module tb_jk_bank_driver;

    localparam int W  = 4;
    localparam int MR = 3;

    logic         Clk         = 1'b0;
    logic         Rst         = 1'b1;
    logic         In_valid    = 1'b1;
    logic         Toggle_pref = 1'b0;
    logic [W-1:0] Target      = 4'b1111;
    logic         In_ready;
    logic [W-1:0] Q_fb;
    logic [W-1:0] J;
    logic [W-1:0] K;
    logic         Busy;
    logic         Done;
    logic         Err;

    jk_bank_driver #(.WIDTH(W), .MAX_RETRY(MR)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .In_valid   (In_valid),
        .In_ready   (In_ready),
        .Target     (Target),
        .Toggle_pref(Toggle_pref),
        .Q_fb       (Q_fb),
        .J          (J),
        .K          (K),
        .Busy       (Busy),
        .Done       (Done),
        .Err        (Err)
    );

    always #5 Clk = ~Clk;

    // Behavioural JK bank
    logic [W-1:0] bank     = '0;
    logic         stuck    = 1'b0;
    logic         load_vld = 1'b0;
    logic [W-1:0] load_dat = '0;

    assign Q_fb = stuck ? '0 : bank;

    always @(posedge Clk) begin
        if (load_vld) bank <= load_dat;
        else begin
            for (int i = 0; i < W; i++) begin
                case ({J[i], K[i]})
                    2'b01:   bank[i] <= 1'b0;
                    2'b10:   bank[i] <= 1'b1;
                    2'b11:   bank[i] <= ~bank[i];
                    default: ;
                endcase
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [W-1:0] t;
        logic [W-1:0] j;
        logic [W-1:0] k;
        bit           err;
        bit           stk;
        int           nd;
    } exp_t;

    exp_t sbq[$];

    function automatic void excite(input logic [W-1:0] q, input logic [W-1:0] t, input bit p,
                                   output logic [W-1:0] j, output logic [W-1:0] k);
        for (int i = 0; i < W; i++) begin
            if (q[i] == t[i])  begin j[i] = 1'b0; k[i] = 1'b0; end
            else if (p)        begin j[i] = 1'b1; k[i] = 1'b1; end
            else if (t[i])     begin j[i] = 1'b1; k[i] = 1'b0; end
            else               begin j[i] = 1'b0; k[i] = 1'b1; end
        end
    endfunction

    // A healthy bank reaches the target after one drive; a stuck-at-zero bank never
    // moves, so every attempt sees the same Q and a non-zero target ends in Err.
    function automatic exp_t predict(input logic [W-1:0] q0, input logic [W-1:0] t,
                                     input bit p, input bit stk);
        exp_t e;
        e.t   = t;
        e.stk = stk;
        excite(q0, t, p, e.j, e.k);
        if (q0 == t || !stk) begin
            e.nd  = 1;
            e.err = 1'b0;
        end else begin
            e.nd  = MR + 1;
            e.err = 1'b1;
        end
        return e;
    endfunction

    // Monitor
    bit   seen_rst = 1'b0;
    bit   active   = 1'b0;
    int   kc       = 0;
    exp_t cur;

    always @(posedge Clk) if (Rst) seen_rst <= 1'b1;

    always @(negedge Clk) begin
        if (seen_rst) begin
            if (active) begin
                int fin;
                kc++;
                if (kc == 1) begin
                    if (sbq.size() == 0) begin
                        errors++;
                        $display("FAIL sb_underflow: accept seen with no expected entry at %0t", $time);
                        cur = '{t: '0, j: '0, k: '0, err: 1'b0, stk: 1'b1, nd: 1};
                    end else begin
                        cur = sbq.pop_front();
                    end
                end
                fin = 2 * cur.nd + 1;
                chk("j",        J,        ((kc % 2 == 1) && kc < fin) ? cur.j : '0);
                chk("k",        K,        ((kc % 2 == 1) && kc < fin) ? cur.k : '0);
                chk("busy",     Busy,     kc < fin);
                chk("in_ready", In_ready, kc == fin);
                chk("done",     Done,     kc == fin && !cur.err);
                chk("err",      Err,      kc == fin && cur.err);
                if (kc == fin) begin
                    if (!cur.stk) chk("bank", bank, cur.t);
                    active = 1'b0;
                end
                if (Rst) active = 1'b0;
            end else begin
                chk("idle_j",     J,        '0);
                chk("idle_k",     K,        '0);
                chk("idle_busy",  Busy,     0);
                chk("idle_done",  Done,     0);
                chk("idle_err",   Err,      0);
                chk("idle_ready", In_ready, 1);
            end
            if (!active && In_valid && In_ready && !Rst) begin
                active = 1'b1;
                kc     = 0;
            end
        end
    end

    // Stimulus
    task automatic load(input logic [W-1:0] v);
        load_vld = 1'b1;
        load_dat = v;
        @(posedge Clk);
        #1 load_vld = 1'b0;
    endtask

    task automatic settle();
        repeat (2 * MR + 4) @(posedge Clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] t, input bit p, input bit hold);
        bit acc = 1'b0;
        int n   = 0;
        In_valid    = 1'b1;
        Target      = t;
        Toggle_pref = p;
        while (!acc && n < 60) begin
            @(negedge Clk);
            if (In_ready && !Rst) begin
                sbq.push_back(predict(Q_fb, t, p, stuck));
                acc = 1'b1;
            end
            n++;
        end
        if (!acc) begin
            errors++;
            $display("FAIL accept_timeout: In_ready never high for target %0h", t);
            In_valid = 1'b0;
        end else begin
            @(posedge Clk);
            #1;
            if (!hold) In_valid = 1'b0;
        end
    endtask

    initial begin
        // Reset held two cycles with a pending request
        repeat (2) @(posedge Clk);
        #1;
        Rst      = 1'b0;
        In_valid = 1'b0;
        repeat (2) @(posedge Clk);
        #1;

        load(4'b0000);
        issue(4'b1010, 1'b0, 1'b0);
        settle();

        load(4'b1010);
        issue(4'b0110, 1'b0, 1'b0);
        settle();
        load(4'b1010);
        issue(4'b0110, 1'b1, 1'b0);
        settle();

        stuck = 1'b1;
        issue(4'b0001, 1'b0, 1'b0);
        settle();
        stuck = 1'b0;

        // Reset during CHECK aborts the request
        load(4'b0011);
        issue(4'b1100, 1'b0, 1'b0);
        @(posedge Clk);
        #1 Rst = 1'b1;
        @(posedge Clk);
        #1 Rst = 1'b0;
        settle();
        issue(4'b0101, 1'b1, 1'b0);
        settle();

        // Target equals bank, In_valid held: second accept right after Done
        load(4'b0101);
        issue(4'b0101, 1'b0, 1'b1);
        issue(4'b0101, 1'b0, 1'b0);
        settle();

        for (int it = 0; it < 40; it++) begin
            stuck = ($urandom_range(0, 4) == 0);
            load(W'($urandom_range(0, 15)));
            issue(W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
            settle();
        end
        stuck = 1'b0;

        chk("sb_empty",   sbq.size(), 0);
        chk("mon_closed", active,     0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
